mode_seq: RTL and testbench
===========================

Name: mode_seq

Overview:
- Upstream sequencer that drives the mode_t control and an 8-bit data stream into the mode-consuming stage.
- On a go request it emits a programmed number of data beats with mode=start, using a valid/ready handshake.
- It then returns mode=done and pulses a completion flag.
- It is the single source of mode for the downstream stage.

Parameters:
- DW, 8, data width of data_out and seed (fixed at 8 to match the downstream out width).
- LENW, 8, width of the beat-count input len.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  start request; sampled only in IDLE.
- len  input  LENW  number of beats to emit; captured on accepted go.
- seed  input  DW  first data value; captured on accepted go.
- busy  output  1  high from the cycle after an accepted go through FINISH.
- mode  output  mode_t  start while a transfer is in progress, otherwise done.
- data_out  output  DW  current beat value.
- valid  output  1  beat on data_out is valid.
- ready  input  1  downstream accepts the beat when valid&&ready.
- done_pulse  output  1  single-cycle pulse at end of transfer.

Behaviour:
- Reset (async, rst_n=0), outputs take these values immediately:
  - state=IDLE, mode=done, busy=0, valid=0, data_out=0, done_pulse=0, beat counter=0.
- Reset asserted mid-transfer aborts it:
  - no done_pulse is produced;
  - on release the block is in IDLE.
- Registered outputs: all outputs are registered; none is combinational from an input.
- States: IDLE, RUN, FINISH. ctrl_state_t is a 2-bit enum.
- IDLE:
  - mode=done, valid=0.
  - go=1 with len!=0: capture len into rem and seed into data_out; next state RUN; next cycle busy=1, mode=start, valid=1.
  - go=1 with len==0: no RUN. Next state FINISH; next cycle busy=1, mode stays done.
  - go=0: stay in IDLE.
- RUN, beat handshake:
  - A beat transfers on a cycle where valid&&ready.
  - On transfer: rem decrements and data_out increments by 1, modulo 2^DW (0xFF wraps to 0x00).
  - Transfer with rem==1: next state FINISH, valid=0, mode=done.
- RUN, stall:
  - valid&&!ready holds data_out and rem stable.
  - valid never drops before its beat is accepted.
- RUN, go handling: go is ignored.
- FINISH:
  - Lasts exactly one cycle: done_pulse=1, busy=1, mode=done, valid=0.
  - Next state IDLE; done_pulse and busy are 0 the following cycle.
  - A new go is accepted in the first IDLE cycle after FINISH.
- Latency and throughput:
  - Accepted go to first valid: 1 cycle.
  - Transfer of N beats with ready tied high: N cycles in RUN.
  - done_pulse occurs 1 cycle after the last beat.
- Simultaneous events: go in FINISH is ignored; it is not queued.
- Width rules:
  - len is unsigned; 255 is the maximum, giving 255 beats.
  - rem is LENW bits wide and never underflows, because exit happens at rem==1.

Decomposition:
- Shared package mytypes holds:
  - mode_t enum {start, done};
  - ctrl_state_t enum {IDLE, RUN, FINISH};
  - constants DW=8 and LENW=8.
- mode_seq imports mytypes::*. No compilation-unit-scope typedefs.
- One sub-module, beat_counter:
  - loadable down-counter with load, dec, and a last flag when rem==1;
  - instantiated once for rem.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, then release with go=0.
   -> mode=done, busy=0, valid=0, data_out=0x00, done_pulse=0 throughout.
2. Basic transfer: go=1, len=4, seed=0x10, ready=1.
   -> valid for 4 consecutive cycles with data 0x10,0x11,0x12,0x13.
   -> mode=start during those 4 cycles.
   -> done_pulse exactly 1 cycle after the 0x13 beat, then busy=0.
3. Backpressure: len=3, seed=0x20, ready pattern 1,0,0,1,1.
   -> 0x21 is held stable for 3 cycles.
   -> exactly 3 beats are accepted (0x20,0x21,0x22), then one done_pulse.
4. Wrap and edge length: len=2 with seed=0xFF, then go with len=0.
   -> first: beats 0xFF then 0x00.
   -> second: no valid, mode stays done, busy=1 for 1 cycle, done_pulse 1 cycle after go.
5. Abort: go with len=10; assert rst_n=0 after the 3rd beat.
   -> outputs return immediately to reset values; no done_pulse.
   -> a new go with len=1 after release completes normally.
6. Ignored go: pulse go during RUN and during FINISH.
   -> no change to rem or data.
   -> the transfer count equals the original len.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the mode sequencer and its downstream stage.
// Holds the mode_t control encoding, the controller state set and the default widths.
package mytypes;

  localparam int DW   = 8;
  localparam int LENW = 8;

  typedef enum logic {
    start = 1'b0,
    done  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/mode_seq_if.sv
// Beat stream from the sequencer to the mode-consuming stage.
// The master drives mode, data and valid; the slave answers with ready.
interface mode_seq_if #(
  parameter int DW = mytypes::DW
);
  import mytypes::*;

  mode_t         mode;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          ready;

  modport master (
    output mode,
    output data_out,
    output valid,
    input  ready
  );

  modport slave (
    input  mode,
    input  data_out,
    input  valid,
    output ready
  );

endinterface

// File: rtl/mode_seq_beat_counter.sv
// Loadable down-counter tracking the beats still owed in the current transfer.
// o_last flags the final beat so the controller exits before the count can underflow.
module beat_counter #(
  parameter int LENW = mytypes::LENW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [LENW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_last
);

  logic [LENW-1:0] r_rem;

  // NOTE: state is cleared on the asynchronous edge of rst_n, so the counter is
  // already zero before the first clock after reset; no synchronous clear is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
    end else if (i_load) begin
      r_rem <= i_load_val;
    end else if (i_dec) begin
      r_rem <= r_rem - 1'b1;
    end
  end

  assign o_last = (r_rem == LENW'(1));

endmodule

// File: rtl/mode_seq.sv
// Upstream sequencer: on go, emits len beats counting up from seed with mode=start,
// then returns mode=done and pulses done_pulse for one cycle. All outputs registered.
module mode_seq #(
  parameter int DW   = mytypes::DW,
  parameter int LENW = mytypes::LENW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic [LENW-1:0] len,
  input  logic [DW-1:0]   seed,
  output logic            busy,
  output logic            done_pulse,
  mode_seq_if.master      bus
);
  import mytypes::*;

  ctrl_state_t   r_state;
  mode_t         r_mode;
  logic          r_busy;
  logic          r_valid;
  logic          r_done_pulse;
  logic [DW-1:0] r_data;

  logic w_load;
  logic w_dec;
  logic w_last;

  // A zero-length request never loads the counter; it goes straight to FINISH.
  assign w_load = (r_state == IDLE) && go && (len != '0);
  assign w_dec  = (r_state == RUN) && r_valid && bus.ready;

  beat_counter #(
    .LENW (LENW)
  ) u_rem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (len),
    .i_dec      (w_dec),
    .o_last     (w_last)
  );

  // NOTE: every register here uses non-blocking assignment so all of them update
  // together from the pre-edge values; blocking would let later lines see new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mode       <= done;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_done_pulse <= 1'b0;
      r_data       <= '0;
    end else begin
      // NOTE: defaulting the pulse low first makes it single-cycle by construction;
      // only the transition into FINISH raises it.
      r_done_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state <= RUN;
              r_mode  <= start;
              r_valid <= 1'b1;
              r_data  <= seed;
            end else begin
              r_state      <= FINISH;
              r_done_pulse <= 1'b1;
            end
          end
        end
        RUN: begin
          // go is deliberately not looked at here; a stalled beat holds data and count.
          if (w_dec) begin
            r_data <= r_data + 1'b1;
            if (w_last) begin
              r_state      <= FINISH;
              r_mode       <= done;
              r_valid      <= 1'b0;
              r_done_pulse <= 1'b1;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_mode  <= done;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode     = r_mode;
  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign busy         = r_busy;
  assign done_pulse   = r_done_pulse;

  // A presented beat stays presented, unchanged, until the consumer takes it.
  a_valid_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (r_valid && !bus.ready) |=> (r_valid && $stable(r_data)));

  a_pulse_single : assert property (@(posedge clk) disable iff (!rst_n)
    r_done_pulse |=> !r_done_pulse);

endmodule

// File: tb/tb_mode_seq.sv
// Self-checking bench for mode_seq: a transfer-level model is compared every cycle,
// and directed scenarios pin beat values, counts and pulse timing with literals.
module tb_mode_seq;
  import mytypes::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] seed = 8'd0;
  logic       busy;
  logic       done_pulse;

  mode_seq_if #(.DW(8)) bus ();

  mode_seq #(.DW(8), .LENW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .len        (len),
    .seed       (seed),
    .busy       (busy),
    .done_pulse (done_pulse),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: beats owed, next beat value, and a pending completion cycle.
  int         m_left = 0;
  logic [7:0] m_data = 8'd0;
  bit         m_fin  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_data = 8'd0;
      m_fin  = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_left > 0) begin
      if (bus.ready) begin
        m_data = m_data + 8'd1;
        m_left = m_left - 1;
        if (m_left == 0) m_fin = 1'b1;
      end
    end else if (go) begin
      if (len != 8'd0) begin
        m_left = int'(len);
        m_data = seed;
      end else begin
        m_fin = 1'b1;
      end
    end
  end

  // Observed traffic: accepted beats and completion pulses.
  logic [7:0] beat_q[$];
  int         dp_cnt = 0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.valid && bus.ready) beat_q.push_back(bus.data_out);
      if (done_pulse) dp_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", 32'(bus.valid), 32'(m_left > 0));
      check("cyc_mode", 32'(bus.mode), 32'((m_left > 0) ? start : done));
      check("cyc_busy", 32'(busy), 32'((m_left > 0) || m_fin));
      check("cyc_done_pulse", 32'(done_pulse), 32'(m_fin));
      check("cyc_data_out", 32'(bus.data_out), 32'(m_data));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_go(input logic [7:0] l, input logic [7:0] s);
    go   = 1'b1;
    len  = l;
    seed = s;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!done_pulse && cyc < maxc) begin
      step();
      cyc++;
    end
    if (cyc >= maxc) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_beats(input string name, input logic [7:0] first, input int n);
    check({name, "_count"}, 32'(beat_q.size()), 32'(n));
    for (int i = 0; i < n && i < beat_q.size(); i++)
      check({name, "_beat"}, 32'(beat_q[i]), 32'(8'(first + 8'(i))));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mode"}, 32'(bus.mode), 32'(done));
    check({name, "_busy"}, 32'(busy), 32'(0));
    check({name, "_valid"}, 32'(bus.valid), 32'(0));
    check({name, "_data"}, 32'(bus.data_out), 32'(8'h00));
    check({name, "_done_pulse"}, 32'(done_pulse), 32'(0));
  endtask

  initial begin
    int cyc;
    int dp_base;
    bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset then idle
    bus.ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    check_reset_outputs("idle");

    // Basic transfer, ready tied high
    bus.ready = 1'b1;
    beat_q.delete();
    dp_cnt = 0;
    do_go(8'd4, 8'h10);
    check("basic_first_valid", 32'(bus.valid), 32'(1));
    check("basic_first_data", 32'(bus.data_out), 32'(8'h10));
    wait_done(20, cyc);
    check("basic_cycles_to_done", 32'(cyc), 32'(4));
    step();
    check("basic_busy_after", 32'(busy), 32'(0));
    check_beats("basic", 8'h10, 4);
    check("basic_pulses", 32'(dp_cnt), 32'(1));

    // Backpressure
    beat_q.delete();
    dp_cnt = 0;
    do_go(8'd3, 8'h20);
    for (int i = 0; i < 5; i++) begin
      bus.ready = pat[i];
      if (i == 2) check("bp_held_data", 32'(bus.data_out), 32'(8'h21));
      step();
    end
    check("bp_done_pulse", 32'(done_pulse), 32'(1));
    step();
    check_beats("bp", 8'h20, 3);
    check("bp_pulses", 32'(dp_cnt), 32'(1));

    // Wrap, then zero-length request
    bus.ready = 1'b1;
    beat_q.delete();
    dp_cnt = 0;
    do_go(8'd2, 8'hFF);
    wait_done(20, cyc);
    check("wrap_cycles_to_done", 32'(cyc), 32'(2));
    step();
    check("wrap_count", 32'(beat_q.size()), 32'(2));
    if (beat_q.size() == 2) begin
      check("wrap_beat0", 32'(beat_q[0]), 32'(8'hFF));
      check("wrap_beat1", 32'(beat_q[1]), 32'(8'h00));
    end
    do_go(8'd0, 8'h55);
    check("zero_busy", 32'(busy), 32'(1));
    check("zero_valid", 32'(bus.valid), 32'(0));
    check("zero_mode", 32'(bus.mode), 32'(done));
    check("zero_done_pulse", 32'(done_pulse), 32'(1));
    step();
    check("zero_busy_after", 32'(busy), 32'(0));
    check("zero_pulse_after", 32'(done_pulse), 32'(0));
    check("zero_beats", 32'(beat_q.size()), 32'(2));
    check("wrap_zero_pulses", 32'(dp_cnt), 32'(2));

    // Abort by reset after the third beat
    beat_q.delete();
    dp_cnt = 0;
    do_go(8'd10, 8'h30);
    repeat (3) step();
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    check_beats("abort", 8'h30, 3);
    check("abort_no_pulse", 32'(dp_cnt), 32'(0));
    beat_q.delete();
    do_go(8'd1, 8'h77);
    wait_done(20, cyc);
    check("after_abort_cycles", 32'(cyc), 32'(1));
    step();
    check_beats("after_abort", 8'h77, 1);
    check("after_abort_pulses", 32'(dp_cnt), 32'(1));

    // go during RUN and FINISH is ignored
    bus.ready = 1'b0;
    beat_q.delete();
    dp_cnt = 0;
    do_go(8'd3, 8'h40);
    do_go(8'd9, 8'h99);
    check("ign_run_data", 32'(bus.data_out), 32'(8'h40));
    bus.ready = 1'b1;
    wait_done(20, cyc);
    dp_base = dp_cnt;
    do_go(8'd5, 8'h5A);
    check("ign_fin_busy", 32'(busy), 32'(0));
    check("ign_fin_valid", 32'(bus.valid), 32'(0));
    step();
    check("ign_fin_still_idle", 32'(bus.valid), 32'(0));
    check_beats("ign", 8'h40, 3);
    check("ign_pulses", 32'(dp_cnt), 32'(dp_base + 1));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
